// File: rtl/sign_engine_sched_if.sv
// rtl/sign_engine_sched_if.sv - AXI4-Stream bundle shared by every stream port of sign_engine_sched
//
// Purpose: one stream channel (payload, sideband and handshake) with source
// and sink views.
// Signals:
//   tdata  [TDATA_WIDTH-1:0]   payload
//   tkeep  [TDATA_WIDTH/8-1:0] byte enables
//   tid    [TID_WIDTH-1:0]     stream id, carried end to end
//   tlast                      last beat of a packet
//   tvalid                     source has a beat
//   tready                     sink accepts the beat
// Modports: m (source side), s (sink side).
interface sign_engine_sched_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 8
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TID_WIDTH-1:0]     tid;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport m (output tdata, tkeep, tid, tlast, tvalid, input tready);
  modport s (input tdata, tkeep, tid, tlast, tvalid, output tready);
endinterface

// File: rtl/sign_engine_sched.sv
// rtl/sign_engine_sched.sv - two-requester packet scheduler in front of a shared hash/sign engine
//
// Purpose: arbitrates whole packets from two requesters onto one engine
// input, remembers who owns each outstanding packet in a tag FIFO, and
// steers the in-order engine results back to the owner.
// Ports:
//   aclk        clock, rising edge
//   areset      asynchronous active-low reset
//   s_axis_0/1  requester packet inputs (sink)
//   m_axis_eng  packets to the engine (source)
//   s_axis_eng  results from the engine (sink)
//   m_axis_0/1  results back to requester 0/1 (source)
//   pkt_cnt_0/1 packets granted per requester, wrapping
//   err_orphan  sticky: engine produced a result with no tag outstanding
module sign_engine_sched #(
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int TAG_DEPTH        = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  sign_engine_sched_if.s        s_axis_0,
  sign_engine_sched_if.s        s_axis_1,
  sign_engine_sched_if.m        m_axis_eng,
  sign_engine_sched_if.s        s_axis_eng,
  sign_engine_sched_if.m        m_axis_0,
  sign_engine_sched_if.m        m_axis_1,
  output logic [31:0]           pkt_cnt_0,
  output logic [31:0]           pkt_cnt_1,
  output logic                  err_orphan
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int KW = AXIS_TDATA_WIDTH / 8;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  // grant holds the requester currently (or most recently) granted, so it
  // doubles as the round-robin pointer. Reset value 1 lets requester 0 win
  // the first contention.
  logic grant, grant_nxt;
  logic push, pop;
  logic eng_valid;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          tag_cnt;
  logic                 full, empty, head;

  logic [AXIS_TDATA_WIDTH-1:0] eng_tdata;
  logic [KW-1:0]               eng_tkeep;

  assign full  = (tag_cnt == FULL_CNT);
  assign empty = (tag_cnt == '0);
  assign head  = tag_mem[rd_ptr];

  // Request path: payload is always muxed from the granted input, only
  // tvalid/tready are qualified by the FSM.
  assign eng_tdata         = grant ? s_axis_1.tdata : s_axis_0.tdata;
  assign eng_tkeep         = grant ? s_axis_1.tkeep : s_axis_0.tkeep;
  assign m_axis_eng.tdata  = eng_tdata;
  assign m_axis_eng.tkeep  = eng_tkeep;
  assign m_axis_eng.tid    = grant ? s_axis_1.tid   : s_axis_0.tid;
  assign m_axis_eng.tlast  = grant ? s_axis_1.tlast : s_axis_0.tlast;
  assign m_axis_eng.tvalid = eng_valid;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    push            = 1'b0;
    eng_valid       = 1'b0;
    s_axis_0.tready = 1'b0;
    s_axis_1.tready = 1'b0;
    case (state)
      IDLE: begin
        if (!full && (s_axis_0.tvalid || s_axis_1.tvalid)) begin
          push      = 1'b1;
          state_nxt = BUSY;
          if (s_axis_0.tvalid && s_axis_1.tvalid) grant_nxt = ~grant;
          else                                    grant_nxt = s_axis_1.tvalid;
        end
      end
      BUSY: begin
        eng_valid       = grant ? s_axis_1.tvalid : s_axis_0.tvalid;
        s_axis_0.tready = !grant && m_axis_eng.tready;
        s_axis_1.tready =  grant && m_axis_eng.tready;
        if (eng_valid && m_axis_eng.tready && m_axis_eng.tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      grant     <= 1'b1;
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
    end else if (push) begin
      grant <= grant_nxt;
      if (grant_nxt) pkt_cnt_1 <= pkt_cnt_1 + 32'd1;
      else           pkt_cnt_0 <= pkt_cnt_0 + 32'd1;
    end
  end

  // Tag FIFO: one bit per outstanding packet naming its owner. The engine
  // returns results in order, so the head tag always owns the current result.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_nxt;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      tag_cnt <= tag_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Result path: broadcast payload, steer tvalid/tready by the head tag.
  // With no tag outstanding the result is refused rather than dropped.
  assign m_axis_0.tdata  = s_axis_eng.tdata;
  assign m_axis_0.tkeep  = s_axis_eng.tkeep;
  assign m_axis_0.tid    = s_axis_eng.tid;
  assign m_axis_0.tlast  = s_axis_eng.tlast;
  assign m_axis_1.tdata  = s_axis_eng.tdata;
  assign m_axis_1.tkeep  = s_axis_eng.tkeep;
  assign m_axis_1.tid    = s_axis_eng.tid;
  assign m_axis_1.tlast  = s_axis_eng.tlast;
  assign m_axis_0.tvalid = !empty && !head && s_axis_eng.tvalid;
  assign m_axis_1.tvalid = !empty &&  head && s_axis_eng.tvalid;
  assign s_axis_eng.tready = !empty && (head ? m_axis_1.tready : m_axis_0.tready);
  assign pop = s_axis_eng.tvalid && s_axis_eng.tready && s_axis_eng.tlast;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset)                          err_orphan <= 1'b0;
    else if (s_axis_eng.tvalid && empty)  err_orphan <= 1'b1;
  end
endmodule

// File: doc/sign_engine_sched.md
SIGN_ENGINE_SCHED -- requirements
Module: sign_engine_sched

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 512, data width of every stream.
REQ-002 SHALL have parameter TAG_DEPTH, default 4, maximum outstanding packets in the engine (power of 2, at least 2).
REQ-003 SHALL have port aclk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_0, AXI4SR.s, full bundle: requester 0 packet input.
REQ-006 SHALL have port s_axis_1, AXI4SR.s, full bundle: requester 1 packet input.
REQ-007 SHALL have port m_axis_eng, AXI4SR.m, full bundle: packets to the shared hash/sign engine.
REQ-008 SHALL have port s_axis_eng, AXI4SR.s, full bundle: signature results from the engine.
REQ-009 SHALL have port m_axis_0, AXI4SR.m, full bundle: results returned to requester 0.
REQ-010 SHALL have port m_axis_1, AXI4SR.m, full bundle: results returned to requester 1.
REQ-011 SHALL have port pkt_cnt_0, output, 32 bits: packets granted to requester 0.
REQ-012 SHALL have port pkt_cnt_1, output, 32 bits: packets granted to requester 1.
REQ-013 SHALL have port err_orphan, output, 1 bit: sticky flag, result seen with no tag outstanding.

Function
REQ-014 SHALL arbitrate at packet granularity with a two-state FSM: IDLE and BUSY.
REQ-015 In IDLE, SHALL select a requester when its tvalid=1 and the tag FIFO is not full.
- Next state: BUSY.
- Grant registered; forwarding starts the following cycle.
REQ-016 When both requesters are valid in IDLE, SHALL grant the one not granted last (round-robin).
- First contention after reset: requester 0 wins.
REQ-017 In BUSY, SHALL pass tdata/tkeep/tid/tlast/tvalid of the granted input combinationally to m_axis_eng.
- Granted tready = m_axis_eng.tready.
- Non-granted tready = 0.
REQ-018 SHALL return to IDLE on the cycle after a handshake with tlast=1 on m_axis_eng.
- Minimum one IDLE cycle between packets.
REQ-019 SHALL push the granted requester index into the tag FIFO on the IDLE->BUSY transition.
REQ-020 SHALL increment the matching pkt_cnt on that same transition; counters wrap 0xFFFFFFFF->0.
REQ-021 SHALL route s_axis_eng to m_axis_<head tag> combinationally while the tag FIFO is non-empty.
- s_axis_eng.tready = selected output's tready.
- Other output tvalid = 0.
REQ-022 SHALL pop the tag FIFO on an s_axis_eng handshake with tlast=1.
REQ-023 Simultaneous push and pop SHALL both take effect, including when the FIFO is full; occupancy is unchanged.
REQ-024 With the tag FIFO empty and s_axis_eng.tvalid=1:
- SHALL hold s_axis_eng.tready=0 and keep both result outputs invalid.
- SHALL set err_orphan=1 (sticky until reset).
REQ-025 With the tag FIFO full, SHALL stay in IDLE; both input treadys stay 0.
REQ-026 Tag FIFO pointers SHALL wrap modulo TAG_DEPTH; full/empty SHALL be decided by a (log2(TAG_DEPTH)+1)-bit occupancy count.
REQ-027 Payload fields SHALL pass unmodified; tid is preserved end to end.

Reset
REQ-028 On areset=0, asynchronously:
- FSM = IDLE; round-robin pointer = requester 1 (so requester 0 wins next).
- Tag FIFO emptied; pkt_cnt_0/1 = 0; err_orphan = 0.
REQ-029 During reset, every tvalid and tready output SHALL be 0.
REQ-030 Reset mid-packet SHALL abandon the packet and any outstanding tags; no partial state survives deassertion.

Verification
REQ-031 Single packet: s_axis_0 sends 3 beats (tid=5) with the engine ready.
- Required: beats appear on m_axis_eng starting 1 cycle after tvalid.
- Required: pkt_cnt_0=1.
- Required: a 1-beat engine result appears on m_axis_0 with tid=5.
REQ-032 Contention: both inputs hold 2-beat packets continuously from reset.
- Required: grant order 0,1,0,1.
- Required: after 4 packets, pkt_cnt_0=2 and pkt_cnt_1=2.
REQ-033 Tag full: TAG_DEPTH=4, engine returns no results.
- Required: exactly 4 packets granted, then both treadys 0.
- Required: one result returned -> exactly one further grant.
REQ-034 Backpressure: m_axis_1.tready=0 while a result for requester 1 is pending.
- Required: s_axis_eng.tready=0 and the tag is not popped.
- Required: the result is delivered once tready=1.
REQ-035 Orphan: result tvalid=1 with no packet outstanding.
- Required: err_orphan=1 next cycle, s_axis_eng.tready=0.
- Required: the flag persists until areset=0.
REQ-036 Reset mid-packet: areset=0 on beat 2 of a 4-beat packet.
- Required: all outputs return to reset values immediately.
- Required: a new packet after deassertion is granted to requester 0.
